// File: rtl/hazard_fwd_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_if
//  Description : ID-stage operand/destination info, execute redirect, and the
//                forwarding / stall / flush / counter results of the hazard
//                unit, bundled as one interface.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_fwd_if #(
    parameter int REG_BITS  = 3,
    parameter int CNT_WIDTH = 16
);
    // ID-stage instruction and execute-stage redirect
    logic                   id_valid;
    logic [REG_BITS-1:0]    id_rs;
    logic [REG_BITS-1:0]    id_rt;
    logic                   id_rs_used;
    logic                   id_rt_used;
    logic [REG_BITS-1:0]    id_rd;
    logic                   id_regWrite;
    logic                   id_memRead;
    logic                   ex_redirect;

    // Hazard unit results
    logic [1:0]             forwardA;
    logic [1:0]             forwardB;
    logic                   stall;
    logic                   flush_ifid;
    logic                   flush_idex;
    logic [CNT_WIDTH-1:0]   stall_cnt;
    logic [CNT_WIDTH-1:0]   flush_cnt;
    // Retired WB slot {valid, rd, regWrite, memRead}, for observation only
    logic [REG_BITS+2:0]    wb_slot;

    // Pipeline side: supplies instruction info, consumes the selects
    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_regWrite, id_memRead, ex_redirect,
        input  forwardA, forwardB, stall, flush_ifid, flush_idex,
               stall_cnt, flush_cnt, wb_slot
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_regWrite, id_memRead, ex_redirect,
        output forwardA, forwardB, stall, flush_ifid, flush_idex,
               stall_cnt, flush_cnt, wb_slot
    );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_unit
//  Description : Tracks destinations of instructions in EX/MEM/WB, produces
//                registered forwarding selects for the instruction entering
//                EX, detects load-use hazards and converts an execute-stage
//                redirect into IF/ID and ID/EX flushes. Saturating stall and
//                flush event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit #(
    parameter int REG_BITS  = 3,
    parameter int CNT_WIDTH = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,        // synchronous, active-low
    hazard_fwd_if.slave bus
);

    // Forwarding select encoding
    localparam logic [1:0] C_FWD_RF  = 2'b00;   // register file (or WB bypass)
    localparam logic [1:0] C_FWD_MEM = 2'b01;   // memwb_writeBack
    localparam logic [1:0] C_FWD_EX  = 2'b10;   // exmem_ALURes

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                regWrite;
        logic                memRead;
    } slot_t;

    // Tracked in-flight instructions and registered outputs
    slot_t                ex_s_q,  ex_s_d;
    slot_t                mem_s_q;
    slot_t                wb_s_q;
    logic [1:0]           fwdA_q,  fwdA_d;
    logic [1:0]           fwdB_q,  fwdB_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // Match terms and hazard decisions
    logic w_exA;
    logic w_memA;
    logic w_exB;
    logic w_memB;
    logic w_lu;
    logic w_stall;
    logic w_bubble;

    // Producer/consumer matching and load-use detection against current slots
    always_comb begin
        w_exA   = ex_s_q.valid  & ex_s_q.regWrite  & (ex_s_q.rd  == bus.id_rs) & bus.id_rs_used;
        w_memA  = mem_s_q.valid & mem_s_q.regWrite & (mem_s_q.rd == bus.id_rs) & bus.id_rs_used;
        w_exB   = ex_s_q.valid  & ex_s_q.regWrite  & (ex_s_q.rd  == bus.id_rt) & bus.id_rt_used;
        w_memB  = mem_s_q.valid & mem_s_q.regWrite & (mem_s_q.rd == bus.id_rt) & bus.id_rt_used;
        // A load one slot ahead cannot supply its data in time: one bubble
        w_lu    = bus.id_valid & ex_s_q.valid & ex_s_q.memRead & (w_exA | w_exB);
        // Redirect squashes the ID instruction, so it must not also stall
        w_stall = w_lu & ~bus.ex_redirect;
        // ID instruction does not enter EX this cycle
        w_bubble = bus.ex_redirect | w_lu | ~bus.id_valid;
    end

    // Next-state for the EX slot, forwarding selects and event counters
    always_comb begin
        ex_s_d      = '0;
        fwdA_d      = C_FWD_RF;
        fwdB_d      = C_FWD_RF;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!w_bubble) begin
            ex_s_d.valid    = 1'b1;
            ex_s_d.rd       = bus.id_rd;
            ex_s_d.regWrite = bus.id_regWrite;
            ex_s_d.memRead  = bus.id_memRead;

            // Newer producer (EX) takes priority over MEM
            if (w_exA) begin
                fwdA_d = C_FWD_EX;
            end else if (w_memA) begin
                fwdA_d = C_FWD_MEM;
            end

            if (w_exB) begin
                fwdB_d = C_FWD_EX;
            end else if (w_memB) begin
                fwdB_d = C_FWD_MEM;
            end
        end

        if (w_stall && (stall_cnt_q != C_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (bus.ex_redirect && (flush_cnt_q != C_CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Slot shift register, forwarding selects and counters; downstream of ID
    // the pipeline never freezes, so MEM/WB always advance
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_s_q      <= '0;
            mem_s_q     <= '0;
            wb_s_q      <= '0;
            fwdA_q      <= C_FWD_RF;
            fwdB_q      <= C_FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_s_q      <= ex_s_d;
            mem_s_q     <= ex_s_q;
            wb_s_q      <= mem_s_q;
            fwdA_q      <= fwdA_d;
            fwdB_q      <= fwdB_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.forwardA   = fwdA_q;
    assign bus.forwardB   = fwdB_q;
    assign bus.stall      = w_stall;
    assign bus.flush_ifid = bus.ex_redirect;
    assign bus.flush_idex = bus.ex_redirect | w_lu;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
    // WB is covered by register-file write-through; visible for debug only
    assign bus.wb_slot    = wb_s_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_fwd_unit
//  Description : Directed and random checks of hazard_fwd_unit against a
//                history-based reference model (nearest-producer search).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_unit;

    logic clk;
    logic rst;

    hazard_fwd_if #(.REG_BITS(3), .CNT_WIDTH(16)) hif  ();
    hazard_fwd_if #(.REG_BITS(3), .CNT_WIDTH(4))  hif4 ();

    hazard_fwd_unit #(.REG_BITS(3), .CNT_WIDTH(16)) dut  (.clk(clk), .rst(rst), .bus(hif.slave));
    hazard_fwd_unit #(.REG_BITS(3), .CNT_WIDTH(4))  dut4 (.clk(clk), .rst(rst), .bus(hif4.slave));

    // The narrow-counter instance sees identical stimulus
    assign hif4.id_valid    = hif.id_valid;
    assign hif4.id_rs       = hif.id_rs;
    assign hif4.id_rt       = hif.id_rt;
    assign hif4.id_rs_used  = hif.id_rs_used;
    assign hif4.id_rt_used  = hif.id_rt_used;
    assign hif4.id_rd       = hif.id_rd;
    assign hif4.id_regWrite = hif.id_regWrite;
    assign hif4.id_memRead  = hif.id_memRead;
    assign hif4.ex_redirect = hif.ex_redirect;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v;
        logic [2:0] rd;
        logic       rw;
        logic       mr;
    } ent_t;

    ent_t       hist[$];         // hist[0] = most recently issued (EX), [1] MEM, [2] WB
    logic [1:0] m_fa, m_fb;
    int         tot_stall, tot_flush;

    // Distance to nearest in-flight writer of r: 1 ahead -> 10, 2 ahead -> 01
    function automatic logic [1:0] m_fwd(input logic [2:0] r, input logic used);
        for (int a = 0; a < 2; a++) begin
            if (used && hist[a].v && hist[a].rw && hist[a].rd == r)
                return (a == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic bit m_lu();
        return hif.id_valid && hist[0].v && hist[0].mr &&
               (m_fwd(hif.id_rs, hif.id_rs_used) == 2'b10 ||
                m_fwd(hif.id_rt, hif.id_rt_used) == 2'b10);
    endfunction

    function automatic bit m_stall();
        return m_lu() && !hif.ex_redirect;
    endfunction

    function automatic int sat(input int t, input int w);
        return (t > (1 << w) - 1) ? (1 << w) - 1 : t;
    endfunction

    // Advance model and DUT by one clock edge
    task automatic tick();
        ent_t       ne;
        logic [1:0] na, nb;
        bit         bub;
        ne = '0; na = 2'b00; nb = 2'b00;
        if (rst) begin
            bub = hif.ex_redirect || m_lu() || !hif.id_valid;
            if (!bub) begin
                ne.v  = 1'b1;
                ne.rd = hif.id_rd;
                ne.rw = hif.id_regWrite;
                ne.mr = hif.id_memRead;
                na    = m_fwd(hif.id_rs, hif.id_rs_used);
                nb    = m_fwd(hif.id_rt, hif.id_rt_used);
            end
            if (m_stall())       tot_stall++;
            if (hif.ex_redirect) tot_flush++;
        end
        @(posedge clk);
        if (!rst) begin
            hist = '{ent_t'(0), ent_t'(0), ent_t'(0)};
            m_fa = 2'b00; m_fb = 2'b00;
            tot_stall = 0; tot_flush = 0;
        end else begin
            hist.push_front(ne);
            void'(hist.pop_back());
            m_fa = na; m_fb = nb;
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] rs, input bit rsu,
                         input logic [2:0] rt, input bit rtu, input logic [2:0] rd,
                         input bit rw, input bit mr, input bit redir);
        hif.id_valid = v;  hif.id_rs = rs; hif.id_rs_used = rsu;
        hif.id_rt = rt;    hif.id_rt_used = rtu; hif.id_rd = rd;
        hif.id_regWrite = rw; hif.id_memRead = mr; hif.ex_redirect = redir;
    endtask

    task automatic nop();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        nop();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                  3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        @(negedge clk);
        n_vec++;
        if (hif.forwardA !== 2'b00 || hif.forwardB !== 2'b00) begin
            n_err++; $display("FAIL reset_fwd: got A=%b B=%b want 00 00", hif.forwardA, hif.forwardB);
        end
        n_vec++;
        if (hif.stall !== 1'b0) begin
            n_err++; $display("FAIL reset_stall: got %b want 0", hif.stall);
        end
        n_vec++;
        if (hif.stall_cnt !== 16'd0 || hif.flush_cnt !== 16'd0) begin
            n_err++; $display("FAIL reset_cnt: got stall_cnt=%0d flush_cnt=%0d want 0 0", hif.stall_cnt, hif.flush_cnt);
        end
        n_vec++;
        if (hif.flush_ifid !== hif.ex_redirect || hif.flush_idex !== hif.ex_redirect) begin
            n_err++; $display("FAIL reset_flush: got ifid=%b idex=%b want %b", hif.flush_ifid, hif.flush_idex, hif.ex_redirect);
        end
        rst = 1'b1;
        nop();
        tick();
    endtask

    task automatic test_ex_fwd();
        do_reset();
        drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);   // ADD r1
        tick();
        drive(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);   // ADD r2,r1,r3
        @(negedge clk);
        n_vec++;
        if (hif.stall !== 1'b0) begin
            n_err++; $display("FAIL ex_fwd_stall: got %b want 0", hif.stall);
        end
        tick();
        nop();
        @(negedge clk);
        n_vec++;
        if (hif.forwardA !== 2'b10 || hif.forwardB !== 2'b00) begin
            n_err++; $display("FAIL ex_fwd_sel: got A=%b B=%b want 10 00", hif.forwardA, hif.forwardB);
        end
        tick();
    endtask

    task automatic test_mem_fwd();
        for (int gap = 1; gap <= 2; gap++) begin
            do_reset();
            drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);  // producer r1
            tick();
            for (int k = 0; k < gap; k++) begin
                drive(1'b1, 3'd6, 1'b1, 3'd7, 1'b1, 3'(5 + k), 1'b1, 1'b0, 1'b0);
                tick();
            end
            drive(1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);  // consumer rt=1
            tick();
            nop();
            @(negedge clk);
            n_vec++;
            if (hif.forwardB !== ((gap == 1) ? 2'b01 : 2'b00)) begin
                n_err++; $display("FAIL mem_fwd_gap%0d: got B=%b want %b", gap, hif.forwardB,
                                  (gap == 1) ? 2'b01 : 2'b00);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0);   // LD r4
        tick();
        drive(1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);   // consumer rt=4
        @(negedge clk);
        n_vec++;
        if (hif.stall !== 1'b1 || hif.flush_idex !== 1'b1 || hif.flush_ifid !== 1'b0) begin
            n_err++; $display("FAIL lu_hazard: got stall=%b idex=%b ifid=%b want 1 1 0",
                              hif.stall, hif.flush_idex, hif.flush_ifid);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (hif.stall !== 1'b0 || hif.flush_idex !== 1'b0) begin
            n_err++; $display("FAIL lu_release: got stall=%b idex=%b want 0 0", hif.stall, hif.flush_idex);
        end
        n_vec++;
        if (hif.stall_cnt !== 16'd1) begin
            n_err++; $display("FAIL lu_cnt: got %0d want 1", hif.stall_cnt);
        end
        tick();
        nop();
        @(negedge clk);
        n_vec++;
        if (hif.forwardB !== 2'b01 || hif.forwardA !== 2'b00) begin
            n_err++; $display("FAIL lu_fwd: got A=%b B=%b want 00 01", hif.forwardA, hif.forwardB);
        end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0);   // LD r4
        tick();
        drive(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1);   // consumer + redirect
        @(negedge clk);
        n_vec++;
        if (hif.stall !== 1'b0 || hif.flush_ifid !== 1'b1 || hif.flush_idex !== 1'b1) begin
            n_err++; $display("FAIL redir_out: got stall=%b ifid=%b idex=%b want 0 1 1",
                              hif.stall, hif.flush_ifid, hif.flush_idex);
        end
        tick();
        nop();
        @(negedge clk);
        n_vec++;
        if (hif.flush_cnt !== 16'd1 || hif.stall_cnt !== 16'd0) begin
            n_err++; $display("FAIL redir_cnt: got flush_cnt=%0d stall_cnt=%0d want 1 0", hif.flush_cnt, hif.stall_cnt);
        end
        n_vec++;
        if (hif.forwardA !== 2'b00 || hif.forwardB !== 2'b00) begin
            n_err++; $display("FAIL redir_fwd: got A=%b B=%b want 00 00", hif.forwardA, hif.forwardB);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);   // LD r2
            tick();
            drive(1'b1, 3'd2, 1'b1, 3'd7, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);   // consumer rs=2
            tick();
            tick();                                                          // consumer issues
            @(negedge clk);
            n_vec++;
            if (hif4.stall_cnt !== 4'((i > 15) ? 15 : i)) begin
                n_err++; $display("FAIL sat_cnt4 iter %0d: got %0d want %0d", i, hif4.stall_cnt, (i > 15) ? 15 : i);
            end
        end
        n_vec++;
        if (hif.stall_cnt !== 16'd20) begin
            n_err++; $display("FAIL sat_cnt16: got %0d want 20", hif.stall_cnt);
        end
        nop();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 49) != 0);
            drive($urandom_range(0, 5) != 0, 3'($urandom_range(0, 3)), 1'($urandom),
                  3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0);
            @(negedge clk);
            n_vec++;
            if (hif.stall !== m_stall() || hif.flush_ifid !== hif.ex_redirect ||
                hif.flush_idex !== (hif.ex_redirect | m_lu())) begin
                n_err++; $display("FAIL rnd_comb c%0d: got stall=%b ifid=%b idex=%b want %b %b %b", c,
                                  hif.stall, hif.flush_ifid, hif.flush_idex,
                                  m_stall(), hif.ex_redirect, hif.ex_redirect | m_lu());
            end
            n_vec++;
            if (hif.forwardA !== m_fa || hif.forwardB !== m_fb) begin
                n_err++; $display("FAIL rnd_fwd c%0d: got A=%b B=%b want %b %b", c,
                                  hif.forwardA, hif.forwardB, m_fa, m_fb);
            end
            n_vec++;
            if (int'(hif.stall_cnt) != sat(tot_stall, 16) || int'(hif.flush_cnt) != sat(tot_flush, 16) ||
                int'(hif4.stall_cnt) != sat(tot_stall, 4) || int'(hif4.flush_cnt) != sat(tot_flush, 4)) begin
                n_err++; $display("FAIL rnd_cnt c%0d: got s=%0d f=%0d s4=%0d f4=%0d want totals s=%0d f=%0d", c,
                                  hif.stall_cnt, hif.flush_cnt, hif4.stall_cnt, hif4.flush_cnt, tot_stall, tot_flush);
            end
            n_vec++;
            if (hif.wb_slot !== hist[2]) begin
                n_err++; $display("FAIL rnd_wb c%0d: got %b want %b", c, hif.wb_slot, hist[2]);
            end
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        hist = '{ent_t'(0), ent_t'(0), ent_t'(0)};
        m_fa = 2'b00; m_fb = 2'b00;
        tot_stall = 0; tot_flush = 0;
        rst = 1'b0;
        nop();
        test_reset();
        test_ex_fwd();
        test_mem_fwd();
        test_load_use();
        test_redirect();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
